// File: rtl/recursive_and_acc_pkg.sv
// recursive_and_acc_pkg
// Shared definitions for the recursive_and_acc block:
//   state_e       controller state encoding
//   ALL_ONES_MAX  all-ones source, sliced down to the data width W (W <= 64)
package recursive_and_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [63:0] ALL_ONES_MAX = '1;

endpackage

// File: rtl/recursive_and_acc_if.sv
// recursive_and_acc_if
// Input and output valid/ready channels of recursive_and_acc.
//   in_data/in_valid/in_last  upstream beat, in_ready back-pressure
//   out_data/out_count/out_zero/out_ones/out_valid  packet result, out_ready accept
// slave  : the accumulator block
// master : upstream source and downstream sink combined
interface recursive_and_acc_if #(
    parameter int S = 3,
    parameter int C = 2
);
    localparam int W = 2**S;

    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic [C:0]   out_count;
    logic         out_zero;
    logic         out_ones;
    logic         out_valid;
    logic         out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_count, out_zero, out_ones, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_count, out_zero, out_ones, out_valid
    );
endinterface

// File: rtl/recursive_and_acc_and.sv
// recursive_and
// Bitwise AND of two 2**S-bit words, built by splitting the word in half
// and recursing until single bits remain.
//   a_i, b_i  operands
//   y_o       a_i & b_i
module recursive_and #(
    parameter int S = 3
) (
    input  logic [2**S-1:0] a_i,
    input  logic [2**S-1:0] b_i,
    output logic [2**S-1:0] y_o
);
    localparam int W = 2**S;

    generate
        if (S == 0) begin : g_leaf
            assign y_o = a_i & b_i;
        end else begin : g_split
            localparam int H = W / 2;

            recursive_and #(.S(S-1)) u_lo (
                .a_i (a_i[H-1:0]),
                .b_i (b_i[H-1:0]),
                .y_o (y_o[H-1:0])
            );

            recursive_and #(.S(S-1)) u_hi (
                .a_i (a_i[W-1:H]),
                .b_i (b_i[W-1:H]),
                .y_o (y_o[W-1:H])
            );
        end
    endgenerate
endmodule

// File: rtl/recursive_and_acc.sv
// recursive_and_acc
// Folds a packet of W-bit beats into one AND-reduced word. A packet ends on
// in_last or after MAXB = 2**C beats, whichever comes first. The result,
// its beat count and zero/ones flags are held until the sink takes them.
//   clk, reset  clock, synchronous active-high reset
//   bus         slave side of recursive_and_acc_if (input and output channels)
//
// state | meaning
// IDLE  | no beat of the current packet accepted yet
// ACCUM | at least one beat folded into acc_q
// HOLD  | result presented on the output, input stalled
module recursive_and_acc
    import recursive_and_acc_pkg::*;
#(
    parameter int S = 3,
    parameter int C = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    recursive_and_acc_if.slave   bus
);
    localparam int W = 2**S;
    localparam logic [W-1:0] ONES    = ALL_ONES_MAX[W-1:0];
    localparam logic [C:0]   MAXB    = {1'b1, {C{1'b0}}};
    localparam logic [C:0]   CNT_ONE = {{C{1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [W-1:0] acc_q, acc_d;
    logic [C:0]   cnt_q, cnt_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [C:0]   out_count_q, out_count_d;
    logic         out_zero_q, out_zero_d;
    logic         out_ones_q, out_ones_d;
    logic         out_valid_q, out_valid_d;

    logic [W-1:0] fold;
    logic [C:0]   cnt_next;
    logic         in_ready;
    logic         in_fire;
    logic         out_fire;
    logic         terminate;

    recursive_and #(.S(S)) u_and (
        .a_i (acc_q),
        .b_i (bus.in_data),
        .y_o (fold)
    );

    assign in_ready  = (state_q != HOLD);
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid_q & bus.out_ready;
    assign cnt_next  = cnt_q + CNT_ONE;
    // MAXB-th beat terminates regardless of in_last, so last-on-MAXB ends once
    assign terminate = bus.in_last | (cnt_next == MAXB);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_zero_d  = out_zero_q;
        out_ones_d  = out_ones_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE, ACCUM: begin
                if (in_fire) begin
                    if (terminate) begin
                        out_data_d  = fold;
                        out_count_d = cnt_next;
                        out_zero_d  = (fold == '0);
                        out_ones_d  = (fold == ONES);
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        acc_d   = fold;
                        cnt_d   = cnt_next;
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                // the result is released only here, so in_ready reopens a
                // cycle after out_fire and packets never pass through
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    acc_d       = ONES;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                acc_d       = ONES;
                cnt_d       = '0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= ONES;
            cnt_q       <= '0;
            out_data_q  <= ONES;
            out_count_q <= '0;
            out_zero_q  <= 1'b0;
            out_ones_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_zero_q  <= out_zero_d;
            out_ones_q  <= out_ones_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_ones  = out_ones_q;
    assign bus.out_valid = out_valid_q;
endmodule
